// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, one bit per cycle on operand
// magnitudes. A final FIX cycle applies sign correction and registers the result.
// Divide-by-zero and signed overflow bypass the iteration and go straight to FIX.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_ni    synchronous active-low reset
//   start_i   request, accepted only while idle and not killed
//   funct3_i  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a_i    rs1 operand (multiplicand / dividend)
//   op_b_i    rs2 operand (multiplier / divisor)
//   kill_i    abort any in-flight operation; also blocks acceptance
//   busy_o    operation in progress
//   done_o    one-cycle pulse, result_o valid
//   result_o  registered result, held until the next done
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpRem    = 3'b110;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              special_q, special_d;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [XLEN-1:0]   m_q, m_d;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Acceptance decode
  logic            accept;
  logic            is_div_in, signed_a_in, signed_b_in, sa_in, sb_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero_in, ovf_in, special_in;
  logic [XLEN-1:0] special_val;

  assign accept      = (state_q == StIdle) && start_i && !kill_i;
  assign is_div_in   = funct3_i[2];
  assign signed_a_in = (funct3_i == OpMulh) || (funct3_i == OpMulhsu) ||
                       (funct3_i == OpDiv)  || (funct3_i == OpRem);
  assign signed_b_in = (funct3_i == OpMulh) || (funct3_i == OpDiv) || (funct3_i == OpRem);
  assign sa_in       = signed_a_in && op_a_i[XLEN-1];
  assign sb_in       = signed_b_in && op_b_i[XLEN-1];
  assign mag_a_in    = sa_in ? (~op_a_i + 1'b1) : op_a_i;
  assign mag_b_in    = sb_in ? (~op_b_i + 1'b1) : op_b_i;
  assign div_zero_in = is_div_in && (op_b_i == '0);
  assign ovf_in      = ((funct3_i == OpDiv) || (funct3_i == OpRem)) &&
                       (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
  assign special_in  = div_zero_in || ovf_in;

  // funct3[1] separates REM* from DIV*.
  always_comb begin
    special_val = '0;
    if (div_zero_in) begin
      special_val = funct3_i[1] ? op_a_i : '1;
    end else if (ovf_in) begin
      special_val = funct3_i[1] ? '0 : op_a_i;
    end
  end

  // Iteration steps
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, div_hi;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_sh >= {1'b0, m_q};
  // When div_ge holds the true difference is below m_q, so the low bits are exact.
  assign div_diff = div_sh[XLEN-1:0] - m_q;
  assign div_hi   = div_ge ? div_diff : div_sh[XLEN-1:0];

  // Sign correction for the FIX cycle
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_res;

  assign prod = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo  = (sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem  = sa_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    if (special_q) begin
      fix_res = acc_q[XLEN-1:0];
    end else if (!op_q[2]) begin
      fix_res = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      fix_res = op_q[1] ? rem : quo;
    end
  end

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      special_q <= 1'b0;
      m_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      special_q <= special_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_i) state_d = special_in ? StFix : StCalc;
        StCalc:  if (cnt_q == CW'(XLEN - 1)) state_d = StFix;
        StFix:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    special_d = special_q;
    m_d       = m_q;
    acc_d     = acc_q;
    if (accept) begin
      op_d      = funct3_i;
      sa_d      = sa_in;
      sb_d      = sb_in;
      special_d = special_in;
      cnt_d     = '0;
      if (special_in) begin
        m_d   = '0;
        acc_d = {{XLEN{1'b0}}, special_val};
      end else if (is_div_in) begin
        m_d   = mag_b_in;
        acc_d = {{XLEN{1'b0}}, mag_a_in};
      end else begin
        m_d   = mag_a_in;
        acc_d = {{XLEN{1'b0}}, mag_b_in};
      end
    end else if (state_q == StCalc) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = op_q[2] ? {div_hi, acc_q[XLEN-2:0], div_ge} : {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Outputs
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (kill_i) begin
      busy_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (start_i) busy_d = 1'b1;
        StCalc:  busy_d = 1'b1;
        StFix: begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = fix_res;
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
